// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
//   Shared definitions for the nibble-serial adder/subtractor:
//     - NIBBLE    : width of one slice handled by the ripple-carry adder
//     - state_e   : sequencer states (IDLE=0, RUN=1, DONE=2)
//     - signed_ovf: two's-complement overflow from the three sign bits
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Overflow occurs when both operands share a sign and the result's sign
  // differs from it. For subtraction, b_msb is the sign of the inverted B.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// -----------------------------------------------------------------------------
// rca4
//   Purely combinational 4-bit ripple-carry adder.
//   Ports:
//     i_a, i_b  in  [3:0]  addends
//     i_cin     in  1      carry-in
//     o_sum     out [3:0]  i_a + i_b + i_cin (low 4 bits)
//     o_cout    out 1      carry out of bit 3
// -----------------------------------------------------------------------------
module rca4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE-1:0] i_a,
  input  logic [NIBBLE-1:0] i_b,
  input  logic              i_cin,
  output logic [NIBBLE-1:0] o_sum,
  output logic              o_cout
);

  logic [NIBBLE:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < NIBBLE; g++) begin : g_fa
    assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit ripple-carry
//   adder. Operands are latched on an accepted start, then one nibble per
//   clock (LSB first) is pushed through rca4 with the carry registered between
//   nibbles. After WIDTH/4 cycles the result is complete and done pulses.
//   WIDTH must be a multiple of 4 and at least 8.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request, accepted whenever busy=0
//     sub    in   1      0: a+b+cin, 1: a-b (b inverted, carry-in forced to 1)
//     a, b   in   WIDTH  operands, sampled on accepted start
//     cin    in   1      carry-in, sampled on accepted start; ignored if sub=1
//     busy   out  1      high while nibbles are being processed
//     done   out  1      one-cycle pulse: sum/cout/ovf are valid
//     sum    out  WIDTH  result register (fills nibble by nibble during RUN)
//     cout   out  1      carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//     ovf    out  1      two's-complement signed overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                N        = WIDTH / NIBBLE;
  localparam int                IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  state_e             r_state;
  state_e             w_state_next;

  logic [WIDTH-1:0]   r_a_lat;
  logic [WIDTH-1:0]   r_b_lat;     // already inverted for subtraction
  logic               r_carry;     // carry between nibbles
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [NIBBLE-1:0]  w_a_nib;
  logic [NIBBLE-1:0]  w_b_nib;
  logic [NIBBLE-1:0]  w_sum_nib;
  logic               w_cout_nib;

  // A request is taken in IDLE and also in DONE, which gives back-to-back
  // operation without an idle bubble.
  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_state == ST_RUN) && (r_idx == LAST_IDX);

  assign w_a_nib  = r_a_lat[int'(r_idx) * NIBBLE +: NIBBLE];
  assign w_b_nib  = r_b_lat[int'(r_idx) * NIBBLE +: NIBBLE];

  rca4 u_rca4 (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum_nib),
    .o_cout (w_cout_nib)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of the order of the statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would make it hold its value, i.e. infer a latch.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latches, nibble sequencing and result collection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_lat <= '0;
      r_b_lat <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1; the +1 rides in on the first carry.
      r_a_lat <= a;
      r_b_lat <= sub ? ~b : b;
      r_carry <= sub | cin;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_sum[int'(r_idx) * NIBBLE +: NIBBLE] <= w_sum_nib;
      r_carry                               <= w_cout_nib;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_cout_nib;
        r_ovf  <= signed_ovf(r_a_lat[WIDTH-1], r_b_lat[WIDTH-1],
                             w_sum_nib[NIBBLE-1]);
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Directed-vector bench for nibble_serial_adder (WIDTH=16). Inputs are
//   driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int W       = 16;
  localparam int MAX_CYC = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Issues one operation starting from 1 unit after an edge and waits (bounded)
  // for done. Returns the observed results and the latency in edges after E0
  // (-1 when done never arrived). Operands are scrambled right after E0 so
  // only the latched copies can produce the right answer.
  task automatic run_op(input  logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input  logic tcin, input logic tsub,
                        output logic [W-1:0] osum, output logic ocout,
                        output logic oovf, output int olat);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub;
    olat = -1; osum = 'x; ocout = 1'bx; oovf = 1'bx;
    for (int k = 1; k <= MAX_CYC; k++) begin
      @(posedge clk); #1;
      if (done && olat < 0) begin
        olat = k; osum = sum; ocout = cout; oovf = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  task automatic test_arith(input string grp, input vec_t v[]);
    logic [W-1:0] s;
    logic         c, o;
    int           lat;
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, s, c, o, lat);
      n_cmp++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL %s/%s latency: got %0d want 4", grp, v[i].name, lat);
      end
      n_cmp++;
      if (s !== v[i].sum) begin
        n_err++;
        $display("FAIL %s/%s sum: got %h want %h", grp, v[i].name, s, v[i].sum);
      end
      n_cmp++;
      if (c !== v[i].cout) begin
        n_err++;
        $display("FAIL %s/%s cout: got %b want %b", grp, v[i].name, c, v[i].cout);
      end
      n_cmp++;
      if (o !== v[i].ovf) begin
        n_err++;
        $display("FAIL %s/%s ovf: got %b want %b", grp, v[i].name, o, v[i].ovf);
      end
    end
  endtask

  task automatic test_add;
    vec_t v[] = '{
      '{"1234+4321",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
      '{"FFFF+0001",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
      '{"00FF+0F00+1", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0}
    };
    test_arith("add", v);
    // Result must be held in IDLE and done must not repeat.
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || sum !== 16'h1000 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL add_idle_hold: got done=%b busy=%b sum=%h want 0 0 1000",
                 done, busy, sum);
      end
    end
  endtask

  task automatic test_sub;
    vec_t v[] = '{
      '{"0005-0007",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
      '{"0007-0005",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0},
      '{"0007-0005_cin", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0}
    };
    test_arith("sub", v);
  endtask

  task automatic test_ovf;
    vec_t v[] = '{
      '{"7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
      '{"8000-0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
      '{"8000+8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{"0F0F+00F1", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0}
    };
    test_arith("ovf", v);
  endtask

  task automatic test_busy_ignore;
    int lat;
    int extra_done;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // Keep start high with different operands while RUN is in progress.
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_run: got %b want 1", busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 3; k <= MAX_CYC; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL busy_ignore latency: got %0d want 4", lat);
    end
    n_cmp++;
    if (sum !== 16'h3333 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL busy_ignore result: got sum=%h cout=%b ovf=%b want 3333 0 0",
               sum, cout, ovf);
    end
    extra_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    n_cmp++;
    if (extra_done !== 0) begin
      n_err++;
      $display("FAIL busy_ignore no_queue: got %0d busy/done cycles want 0", extra_done);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] s;
    logic         c, o;
    int           lat;
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, s, c, o, lat);
    n_cmp++;
    if (lat !== 4 || s !== 16'h0000 || c !== 1'b1 || o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d sum=%h cout=%b ovf=%b want 4 0000 1 1",
               lat, s, c, o);
    end
    // Now inside the DONE cycle: request the next operation immediately.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done_pulse: got %b want 1", done);
    end
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b cout=%b ovf=%b want 1 0 0 0",
               busy, done, cout, ovf);
    end
    lat = -1;
    for (int k = 1; k <= MAX_CYC; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== 4 || sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d sum=%h cout=%b ovf=%b want 4 5555 0 0",
               lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] s;
    logic         c, o;
    int           lat;
    int           n_done;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || sum[7:0] !== 8'h55) begin
      n_err++;
      $display("FAIL rst_mid_partial: got busy=%b sum[7:0]=%h want 1 55", busy, sum[7:0]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_async: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    n_cmp++;
    if (n_done !== 0 || sum !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_mid_abandon: got %0d busy/done cycles sum=%h want 0 0000",
               n_done, sum);
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, s, c, o, lat);
    n_cmp++;
    if (lat !== 4 || s !== 16'h1000 || c !== 1'b0 || o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_next_op: got lat=%0d sum=%h cout=%b ovf=%b want 4 1000 0 0",
               lat, s, c, o);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
